// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle RISC core: stage encoding,
// opcode values and the opcode classes that select a stage path.
package cpu_pkg;

  typedef enum logic [2:0] {
    IF_STAGE  = 3'b000,
    ID_STAGE  = 3'b001,
    EX_STAGE  = 3'b010,
    MEM_STAGE = 3'b011,
    WB_STAGE  = 3'b100
  } stage_t;

  localparam logic [5:0] OP_AND    = 6'b000000;
  localparam logic [5:0] OP_ADD    = 6'b000001;
  localparam logic [5:0] OP_SUB    = 6'b000010;
  localparam logic [5:0] OP_ANDI   = 6'b000011;
  localparam logic [5:0] OP_ADDI   = 6'b000100;
  localparam logic [5:0] OP_LW     = 6'b000101;
  localparam logic [5:0] OP_LW_POI = 6'b000110;
  localparam logic [5:0] OP_SW     = 6'b000111;
  localparam logic [5:0] OP_BR0    = 6'b001000;
  localparam logic [5:0] OP_BR1    = 6'b001001;
  localparam logic [5:0] OP_BR2    = 6'b001010;
  localparam logic [5:0] OP_BR3    = 6'b001011;
  localparam logic [5:0] OP_JMP    = 6'b001100;
  localparam logic [5:0] OP_CALL   = 6'b001101;
  localparam logic [5:0] OP_RET    = 6'b001110;
  localparam logic [5:0] OP_PUSH   = 6'b001111;
  localparam logic [5:0] OP_POP    = 6'b010000;

  // Each class maps to one stage path after ID
  typedef enum logic [3:0] {
    ALU,
    LOAD,
    STORE,
    BRANCH,
    JUMP,
    STACK_W,
    STACK_R,
    RET,
    ILLEGAL
  } op_class_t;

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode decoder: maps the instruction-register opcode
// to the class that determines the sequencer's stage path.
module op_classifier
  import cpu_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output op_class_t       op_class
);

  // Anything not listed falls through to ILLEGAL
  always_comb begin
    op_class = ILLEGAL;
    case (op)
      OP_W'(OP_AND), OP_W'(OP_ADD), OP_W'(OP_SUB),
      OP_W'(OP_ANDI), OP_W'(OP_ADDI):              op_class = ALU;
      OP_W'(OP_LW), OP_W'(OP_LW_POI):              op_class = LOAD;
      OP_W'(OP_SW):                                op_class = STORE;
      OP_W'(OP_BR0), OP_W'(OP_BR1),
      OP_W'(OP_BR2), OP_W'(OP_BR3):                op_class = BRANCH;
      OP_W'(OP_JMP):                               op_class = JUMP;
      OP_W'(OP_CALL), OP_W'(OP_PUSH):              op_class = STACK_W;
      OP_W'(OP_RET):                               op_class = RET;
      OP_W'(OP_POP):                               op_class = STACK_R;
      default:                                     op_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multicycle RISC core (IF/ID/EX/MEM/WB).
// Optional build macro PERF_CNT_EN adds a retired-instruction counter
// output retired_count of width CNT_W.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W = 6
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OP_W-1:0] OP,
  input  logic            mem_ready,
  output logic [2:0]      state,
  output logic [2:0]      next_state,
  output logic            ir_write,
  output logic            pc_write,
  output logic            instr_done,
  output logic            illegal_op
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] retired_count
`endif
);

  stage_t    state_q;
  stage_t    state_d;
  op_class_t op_class;

  op_classifier #(.OP_W(OP_W)) u_classifier (
    .op       (OP),
    .op_class (op_class)
  );

  assign state      = state_q;
  assign next_state = state_d;

  // Stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_STAGE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-stage selection and the write strobes derived from it
  always_comb begin
    state_d = IF_STAGE;
    case (state_q)
      IF_STAGE: state_d = run ? ID_STAGE : IF_STAGE;
      ID_STAGE: begin
        case (op_class)
          ALU, LOAD, STORE, BRANCH: state_d = EX_STAGE;
          STACK_W, STACK_R, RET:    state_d = MEM_STAGE;
          default:                  state_d = IF_STAGE;
        endcase
      end
      EX_STAGE: begin
        case (op_class)
          ALU:          state_d = WB_STAGE;
          LOAD, STORE:  state_d = MEM_STAGE;
          default:      state_d = IF_STAGE;
        endcase
      end
      MEM_STAGE: begin
        if (!mem_ready) begin
          state_d = MEM_STAGE;
        end else if (op_class == LOAD || op_class == STACK_R) begin
          state_d = WB_STAGE;
        end else begin
          state_d = IF_STAGE;
        end
      end
      WB_STAGE: state_d = IF_STAGE;
      default:  state_d = IF_STAGE;
    endcase
    ir_write = (state_q == IF_STAGE) && run;
    pc_write = (state_q != IF_STAGE) && (state_d == IF_STAGE);
  end

  // Retirement pulse and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      instr_done <= pc_write;
      if (state_q == ID_STAGE && op_class == ILLEGAL) begin
        illegal_op <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (pc_write) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed vector table,
// reset corner cases and randomized instruction streams against a
// stage-path reference model.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] OP;
  logic       mem_ready;
  logic [2:0] state;
  logic [2:0] next_state;
  logic       ir_write;
  logic       pc_write;
  logic       instr_done;
  logic       illegal_op;
`ifdef PERF_CNT_EN
  logic [3:0] retired_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [5:0] op;
    string      seq;
    logic       ill_before;
    logic       ill_after;
  } vec_t;

  vec_t vecs[7];

  multicycle_sequencer #(
    .OP_W(6)
`ifdef PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .state      (state),
    .next_state (next_state),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
`ifdef PERF_CNT_EN
    , .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input string n, input logic [5:0] o, input string s,
                                 input logic b, input logic a);
    vec_t v;
    v.name = n;
    v.op = o;
    v.seq = s;
    v.ill_before = b;
    v.ill_after = a;
    return v;
  endfunction

  // Stage path after IF for an opcode, written straight from the opcode table
  function automatic void getPath(input logic [5:0] op, output string p, output bit ill);
    ill = 1'b0;
    if (op <= 6'd4)                      p = "124";
    else if (op == 6'd5 || op == 6'd6)   p = "1234";
    else if (op == 6'd7)                 p = "123";
    else if (op >= 6'd8 && op <= 6'd11)  p = "12";
    else if (op == 6'd12)                p = "1";
    else if (op >= 6'd13 && op <= 6'd15) p = "13";
    else if (op == 6'd16)                p = "134";
    else begin
      p = "1";
      ill = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic mr);
    run = r;
    OP = o;
    mem_ready = mr;
  endtask

  // Sample all outputs mid-cycle, then advance to just after the next posedge
  task automatic checkCycle(input string tag, input logic [2:0] s, input logic [2:0] n,
                            input logic ir, input logic pc, input logic done, input logic ill);
    @(negedge clk);
    checkOutput({tag, " state"}, 32'(state), 32'(s));
    checkOutput({tag, " next_state"}, 32'(next_state), 32'(n));
    checkOutput({tag, " ir_write"}, 32'(ir_write), 32'(ir));
    checkOutput({tag, " pc_write"}, 32'(pc_write), 32'(pc));
    checkOutput({tag, " instr_done"}, 32'(instr_done), 32'(done));
    checkOutput({tag, " illegal_op"}, 32'(illegal_op), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    string      p;
    bit         ill;
    bit         ill_m;
    logic       prev_pc;
    logic [5:0] op;
    logic [2:0] cur;
    logic [2:0] nxt;
    logic       mr;
    logic       stall;
    int         len;
    int         pos;
    int         stalls;

    vecs[0] = mkVec("ADD",  6'b000001, "01240",    1'b0, 1'b0);
    vecs[1] = mkVec("LW",   6'b000101, "01233340", 1'b0, 1'b0);
    vecs[2] = mkVec("JMP",  6'b001100, "010",      1'b0, 1'b0);
    vecs[3] = mkVec("BEQ",  6'b001010, "0120",     1'b0, 1'b0);
    vecs[4] = mkVec("PUSH", 6'b001111, "0130",     1'b0, 1'b0);
    vecs[5] = mkVec("ILL",  6'b111111, "010",      1'b0, 1'b1);
    vecs[6] = mkVec("ADD2", 6'b000001, "01240",    1'b1, 1'b1);

    rst_n = 1'b0;
    applyStimulus(1'b0, 6'd0, 1'b1);
    #3;
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset instr_done", 32'(instr_done), 32'd0);
    checkOutput("reset illegal_op", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] Directed vector table");
    for (int v = 0; v < 7; v++) begin
      len = vecs[v].seq.len();
      for (int i = 0; i < len; i++) begin
        cur = 3'(vecs[v].seq[i] - 8'd48);
        nxt = (i < len - 1) ? 3'(vecs[v].seq[i+1] - 8'd48) : 3'd0;
        mr = !(cur == 3'd3 && nxt == 3'd3);
        applyStimulus(i == 0, vecs[v].op, mr);
        checkCycle(vecs[v].name, cur, nxt, i == 0, i == len - 2, i == len - 1,
                   (i < 2) ? vecs[v].ill_before : vecs[v].ill_after);
      end
    end

    $display("[TB] Asynchronous reset mid-EX");
    applyStimulus(1'b1, 6'b000001, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 6'b000001, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre-reset state EX", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset state", 32'(state), 32'd0);
    checkOutput("async reset illegal_op", 32'(illegal_op), 32'd0);
    checkOutput("async reset instr_done", 32'(instr_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkCycle("idle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] Randomized instruction stream");
    ill_m = 1'b0;
    prev_pc = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 8) op = 6'($urandom_range(0, 16));
      else op = 6'($urandom);
      getPath(op, p, ill);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        applyStimulus(1'b0, op, 1'($urandom));
        checkCycle("rnd idle", 3'd0, 3'd0, 1'b0, 1'b0, prev_pc, ill_m);
        prev_pc = 1'b0;
      end
      applyStimulus(1'b1, op, 1'($urandom));
      checkCycle("rnd IF", 3'd0, 3'd1, 1'b1, 1'b0, prev_pc, ill_m);
      prev_pc = 1'b0;
      pos = 0;
      stalls = 0;
      len = p.len();
      while (pos < len) begin
        cur = 3'(p[pos] - 8'd48);
        mr = ($urandom_range(0, 3) != 0) || (stalls >= 4);
        stall = (cur == 3'd3) && !mr;
        if (stall) nxt = 3'd3;
        else if (pos + 1 < len) nxt = 3'(p[pos+1] - 8'd48);
        else nxt = 3'd0;
        applyStimulus(1'b0, op, mr);
        checkCycle("rnd", cur, nxt, 1'b0, nxt == 3'd0, prev_pc, ill_m);
        if (cur == 3'd1 && ill) ill_m = 1'b1;
        prev_pc = (nxt == 3'd0);
        if (stall) stalls++;
        else pos++;
      end
    end

`ifdef PERF_CNT_EN
    $display("[TB] Retired counter wrap");
    rst_n = 1'b0;
    #1;
    checkOutput("retired_count reset", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 6'b001100, 1'b1);
    for (int k = 0; k < 34; k++) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 6'b001100, 1'b1);
    @(negedge clk);
    checkOutput("retired_count wrap", 32'(retired_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
